// File: rtl/hilo_unit.sv
// HI/LO register unit: holds the architectural HI/LO pair, sequences
// multi-cycle MULT/DIV completion and serves MFHI/MFLO/MTHI/MTLO.
module hilo_unit #(
    parameter int unsigned MULT_LAT = 3,
    parameter int unsigned DIV_LAT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_MULT = 3'b001,
        OP_DIV  = 3'b010,
        OP_MTHI = 3'b011,
        OP_MTLO = 3'b100,
        OP_MFHI = 3'b101,
        OP_MFLO = 3'b110,
        OP_NOP7 = 3'b111
    } op_t;

    localparam logic [3:0] MULT_INIT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_INIT  = 4'(DIV_LAT - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    op_t        opc;
    logic       real_op;
    logic       accept;
    logic       capture;

    assign busy = (state == BUSY);

    // Decode the op and decide whether it is accepted this cycle
    always_comb begin
        opc     = op_t'(op);
        real_op = 1'b0;
        case (opc)
            OP_MULT, OP_DIV, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO: real_op = 1'b1;
            default:                                            real_op = 1'b0;
        endcase
        stall  = busy && op_valid && real_op;
        accept = op_valid && !stall;
    end

    // Next-state logic: launch MULT/DIV from IDLE, count down in BUSY
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && opc == OP_MULT) begin
                    state_nx = BUSY;
                    cnt_nx   = MULT_INIT;
                end else if (accept && opc == OP_DIV) begin
                    state_nx = BUSY;
                    cnt_nx   = DIV_INIT;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State and latency counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // HI/LO capture, moves to/from HI/LO, and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            if (capture) begin
                hi <= alu_hi;
                lo <= alu_lo;
            end else if (accept) begin
                // Only NOPs are accepted while BUSY, so these never race capture
                case (opc)
                    OP_MTHI: hi <= wdata;
                    OP_MTLO: lo <= wdata;
                    OP_MFHI: begin
                        rdata       <= hi;
                        rdata_valid <= 1'b1;
                    end
                    OP_MFLO: begin
                        rdata       <= lo;
                        rdata_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter MULT_LAT, default 3, cycles from MULT acceptance to HI/LO capture (legal 1..15).
REQ-002 Parameter DIV_LAT, default 4, cycles from DIV acceptance to HI/LO capture (legal 1..15).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  op field is valid this cycle.
REQ-006 op  input  3  000 NOP, 001 MULT, 010 DIV, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO, 111 NOP.
REQ-007 wdata  input  32  source operand for MTHI/MTLO.
REQ-008 alu_hi  input  32  upper result word from the ALU stage.
REQ-009 alu_lo  input  32  lower result word from the ALU stage.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.
REQ-012 rdata  output  32  registered MFHI/MFLO read data.
REQ-013 rdata_valid  output  1  one-cycle pulse, rdata updated this cycle.
REQ-014 busy  output  1  registered, high while a MULT/DIV is in flight.
REQ-015 stall  output  1  combinational, current op not accepted, requester SHALL hold op/op_valid/wdata.

Function
REQ-016 The block SHALL implement two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-017 An op SHALL be accepted on a rising edge iff op_valid=1 and stall=0.
REQ-018 stall SHALL equal busy AND op_valid AND op in {MULT, DIV, MTHI, MTLO, MFHI, MFLO}; NOP and 111 never stall.
REQ-019 Accepted MULT in IDLE: cnt <= MULT_LAT-1, state <= BUSY, busy <= 1.
REQ-020 Accepted DIV in IDLE: cnt <= DIV_LAT-1, state <= BUSY, busy <= 1.
REQ-021 In BUSY with cnt != 0: cnt decrements by 1 per edge; HI/LO unchanged.
REQ-022 In BUSY with cnt == 0: at that edge hi <= alu_hi, lo <= alu_lo, state <= IDLE, busy <= 0.
REQ-023 Net latency: MULT accepted at edge N updates hi/lo at edge N+MULT_LAT; DIV at N+DIV_LAT; busy high for exactly LAT cycles.
REQ-024 The ALU stage SHALL hold alu_hi/alu_lo stable from edge N+LAT-1 to edge N+LAT; values are captured unmodified, including DIV-by-zero results.
REQ-025 Accepted MTHI: hi <= wdata next edge; lo unchanged. Accepted MTLO: lo <= wdata; hi unchanged.
REQ-026 Accepted MFHI: rdata <= hi (pre-edge value), rdata_valid <= 1 for one cycle; MFLO likewise with lo.
REQ-027 MTHI followed next cycle by MFHI SHALL return the newly written value (no bypass needed, register already updated).
REQ-028 rdata SHALL hold its last value when rdata_valid=0; rdata_valid SHALL be 0 in every cycle without an accepted MFHI/MFLO.
REQ-029 Capture edge (cnt==0) with an op presented: busy is still 1, so the op stalls and is accepted on the following edge.
REQ-030 NOP/111 with op_valid=1 SHALL change no state.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force hi=0, lo=0, rdata=0, rdata_valid=0, busy=0, cnt=0, state=IDLE.
REQ-032 Reset asserted during BUSY SHALL abort the operation; no capture occurs after release.
REQ-033 First op SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-034 MULT accepted at edge 1, alu_hi=32'hFFFF_FFFF, alu_lo=32'hFFFF_FFFA (-2*3) -> busy high cycles 1-3, hi/lo updated at edge 4, then MFLO -> rdata=32'hFFFF_FFFA, rdata_valid pulse.
REQ-035 DIV accepted, MFHI presented every cycle -> stall=1 for 4 cycles, MFHI accepted at edge 5 returns alu_hi (remainder, e.g. 1 for 7/2), lo=3.
REQ-036 MTHI wdata=32'hDEAD_BEEF, next cycle MFHI -> rdata=32'hDEAD_BEEF; lo unchanged.
REQ-037 MULT accepted, rst_n pulsed low at cycle 2 -> hi=lo=0, busy=0 asynchronously, no capture at edge 4.
REQ-038 NOP/111 with op_valid=1 during BUSY -> stall=0, no state change; MTLO during BUSY -> stall=1, lo written only after busy falls.
